imem_loader: RTL and testbench

Boot-time writer for the instruction memory of the single-cycle RISC-V core. Receives a length-prefixed little-endian byte stream, typically from a UART receiver, over a valid/ready handshake. Assembles 32-bit instruction words and writes them to consecutive word-aligned instruction-memory addresses. Holds the CPU in reset until the image is fully and correctly loaded.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory of the single-cycle
// RISC-V core. Consumes a length-prefixed little-endian byte stream
// (N as 16-bit LSB first, then 4*N data bytes, each word LSB first) over a
// valid/ready handshake. It assembles the bytes into 32-bit words, writes them
// to consecutive word-aligned addresses, and keeps the CPU held in reset until
// the image is completely loaded.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the modulo-256 sum of all data bytes before reporting Done.
//
// Parameters:
//   ADDR_WIDTH     word-address width; capacity is 2^ADDR_WIDTH words
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-high reset
//   START          single-cycle pulse; begins a load from IDLE/DONE/ERROR
//   ByteValid      stream byte present
//   ByteData       stream byte
//   ByteReady      loader accepts a byte this cycle
//   MemWriteEnable one-cycle write strobe per word
//   MemAddress     word-aligned byte address (word_index*4)
//   MemWriteData   assembled instruction word
//   CPUHold        keeps the core in reset while high
//   Done           image loaded
//   Error          load failed
//   LoadedWords    words written during the current load
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CPUHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] LoadedWords
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHECK
  } state_t;
  localparam state_t S_FINISH = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;
  localparam state_t S_FINISH = S_DONE;
`endif

  // 17 bits so that a full 16-bit count can be compared against capacity.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          count_lo;
  logic [15:0]         count;
  logic [ADDR_WIDTH:0] index;
  logic [1:0]          byte_cnt;
  logic [23:0]         word;
  logic                accept;
  logic                start_load;
  logic                ready_nxt;
  logic [15:0]         hdr_n;
  logic [16:0]         index_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum;
`endif

  // ByteReady is registered from the next state, so it always reflects the
  // current state and can be used directly to qualify the handshake.
  assign accept     = ByteValid && ByteReady;
  assign hdr_n      = {ByteData, count_lo};
  assign index_inc  = 17'(index) + 17'd1;
  assign start_load = START && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_HDR_LO;
      S_HDR_LO: if (accept) state_nxt = S_HDR_HI;
      S_HDR_HI: begin
        if (accept) begin
          if ({1'b0, hdr_n} > CAPACITY) state_nxt = S_ERROR;
          else if (hdr_n == '0)         state_nxt = S_FINISH;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (index_inc < {1'b0, count}) ? S_DATA : S_FINISH;
      S_DONE,
      S_ERROR:  if (START) state_nxt = S_HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:  if (accept) state_nxt = (ByteData == sum) ? S_DONE : S_ERROR;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_nxt = 1'b0;
    case (state_nxt)
      S_HDR_LO, S_HDR_HI, S_DATA: ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:                    ready_nxt = 1'b1;
`endif
      default:                    ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= S_IDLE;
      ByteReady      <= 1'b0;
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemWriteData   <= '0;
      CPUHold        <= 1'b1;
      Done           <= 1'b0;
      Error          <= 1'b0;
      LoadedWords    <= '0;
      count_lo       <= '0;
      count          <= '0;
      index          <= '0;
      byte_cnt       <= '0;
      word           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      state          <= state_nxt;
      ByteReady      <= ready_nxt;
      MemWriteEnable <= (state_nxt == S_WRITE);
      Done           <= (state_nxt == S_DONE);
      Error          <= (state_nxt == S_ERROR);
      CPUHold        <= (state_nxt != S_DONE);

      if (start_load) begin
        index       <= '0;
        LoadedWords <= '0;
        byte_cnt    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum         <= '0;
`endif
      end

      if (accept) begin
        case (state)
          S_HDR_LO: count_lo <= ByteData;
          S_HDR_HI: count    <= hdr_n;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            // Bytes arrive LSB first: shift down so the newest byte sits on top.
            word     <= {ByteData, word[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + ByteData;
`endif
            if (byte_cnt == 2'd3) begin
              MemAddress   <= 32'({index, 2'b00});
              MemWriteData <= {ByteData, word};
            end
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) begin
        index       <= index_inc[ADDR_WIDTH:0];
        LoadedWords <= LoadedWords + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] loaded_words;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RESET(rst), .START(start),
    .ByteValid(byte_valid), .ByteData(byte_data), .ByteReady(byte_ready),
    .MemWriteEnable(mem_we), .MemAddress(mem_addr), .MemWriteData(mem_wdata),
    .CPUHold(cpu_hold), .Done(done), .Error(error), .LoadedWords(loaded_words)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  data_q[$];
  bit          alt_phase = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the loader must not accept a byte in that cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      check("ready_low_during_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  task automatic check_reset_values();
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_loaded_words", {16'b0, loaded_words}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid on alternate cycles, 2: random gaps
  task automatic send(input logic [7:0] b, input int unsigned mode);
    bit          sent = 1'b0;
    int unsigned budget = 0;
    while (!sent && budget < 100) begin
      @(negedge clk);
      budget++;
      alt_phase = ~alt_phase;
      case (mode)
        1:       byte_valid = alt_phase;
        2:       byte_valid = ($urandom_range(0, 1) == 1);
        default: byte_valid = 1'b1;
      endcase
      byte_data = b;
      // ByteReady only changes on rising edges, so its value now is what the
      // next edge samples.
      if (byte_valid && byte_ready) sent = 1'b1;
    end
    check("byte_accepted", {31'b0, sent}, 32'd1);
  endtask

  task automatic run_load(input logic [15:0] n, input int unsigned mode, input bit bad_chk);
    bit          ovf;
    bit          ok;
    logic [7:0]  chk;
    logic [31:0] exp_word;
    int unsigned lat;
    int unsigned exp_lat;
    int unsigned exp_writes;

    ovf = (32'(n) > (32'd1 << AW));
    chk = 8'd0;
    for (int i = 0; i < 4 * int'(n) && !ovf; i++) chk = chk + data_q[i];
    wr_addr_q.delete();
    wr_data_q.delete();

    pulse_start();
    send(n[7:0], mode);
    send(n[15:8], mode);
    if (!ovf) begin
      for (int i = 0; i < 4 * int'(n); i++) send(data_q[i], mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(bad_chk ? chk + 8'd1 : chk, mode);
`endif
    end

    lat = 0;
    do begin
      @(negedge clk);
      byte_valid = 1'b0;
      lat++;
    end while (!(done || error) && lat < 40);

    ok = !ovf;
    exp_lat = (ovf || n == 0) ? 1 : 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = ok && !bad_chk;
    if (!ovf) exp_lat = 1;
`endif
    exp_writes = ovf ? 0 : int'(n);

    check("finish_latency", lat, exp_lat);
    check("done", {31'b0, done}, {31'b0, ok});
    check("error", {31'b0, error}, {31'b0, !ok});
    check("cpu_hold", {31'b0, cpu_hold}, {31'b0, !ok});
    check("loaded_words", {16'b0, loaded_words}, exp_writes);
    check("byte_ready_idle", {31'b0, byte_ready}, 32'd0);
    check("write_count", wr_addr_q.size(), exp_writes);
    for (int i = 0; i < int'(exp_writes) && i < wr_addr_q.size(); i++) begin
      exp_word = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
      check("write_addr", wr_addr_q[i], 32'(i * 4));
      check("write_data", wr_data_q[i], exp_word);
    end
  endtask

  task automatic load_basic();
    data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic load_random(input int unsigned n);
    data_q.delete();
    for (int i = 0; i < 4 * int'(n); i++) data_q.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #12;
    check_reset_values();
    @(negedge clk) rst = 1'b0;

    // Basic load, then with alternating gaps, then random gaps.
    load_basic();
    run_load(16'd2, 0, 1'b0);
    run_load(16'd2, 1, 1'b0);
    run_load(16'd2, 2, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(16'd2, 0, 1'b1);
    run_load(16'd2, 0, 1'b0);
`endif

    // Oversize header, then an empty image.
    data_q.delete();
    run_load(16'h0011, 0, 1'b0);
    run_load(16'hFFFF, 2, 1'b0);
    run_load(16'h0000, 0, 1'b0);

    // Exactly full memory.
    load_random(16);
    run_load(16'd16, 0, 1'b0);

    // Reset mid-load after two data bytes.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h00, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    byte_valid = 1'b0;
    #1;
    check_reset_values();
    check("no_write_before_reset", wr_addr_q.size(), 32'd0);
    @(negedge clk) rst = 1'b0;
    load_basic();
    run_load(16'd2, 0, 1'b0);

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      int unsigned n;
      n = $urandom_range(0, 17);
      load_random(n);
      run_load(16'(n), $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
